regbank_8x32: RTL

- 8-entry x 32-bit register bank; downstream consumer of the 32-bit 1-to-8 write-data demux.
- One write port with valid/ready handshake and a 1-entry write pipeline stage. Two combinational read ports. A sequential clear engine zeroes all entries one per cycle.
- Datapath and register-file storage for the single-cycle processor library. The one-hot word enables are decoded from the write address.

---
 rtl/regbank_8x32.sv | 137 +++++++++++++
 1 files changed

// File: rtl/regbank_8x32.sv
`timescale 1ns/1ps
// regbank_8x32: 8 x 32-bit register bank with a pipelined write port, two
// combinational read ports and a sweep-clear engine. Macro RF_BYPASS_EN enables read forwarding.
module regbank_8x32 #(
    parameter int WIDTH = 32,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr_req,
    output logic             busy,
    output logic             pend,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b
);
    localparam int            DEPTH    = 2**AW;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [AW-1:0]    cnt_reg, cnt_next;
    logic             pend_v_reg, pend_v_next;
    logic [AW-1:0]    pend_addr_reg, pend_addr_next;
    logic [WIDTH-1:0] pend_data_reg, pend_data_next;

    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [DEPTH-1:0] word_en;
    logic [DEPTH-1:0] clr_en;
    logic             wr_accept;

    assign wr_ready  = !rst && (state_reg == IDLE);
    assign wr_accept = wr_valid && wr_ready;
    assign busy      = (state_reg != IDLE);
    assign pend      = pend_v_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (clr_req) begin
                    state_next = (pend_v_reg || wr_accept) ? DRAIN : CLEAR;
                    cnt_next   = '0;
                end
            end
            DRAIN: begin
                state_next = CLEAR;
                cnt_next   = '0;
            end
            CLEAR: begin
                if (cnt_reg == LAST_IDX) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // A held write always commits on the next edge, so the stage only stays
    // full when a new write is accepted on that same edge.
    always_comb begin
        pend_v_next    = wr_accept;
        pend_addr_next = pend_addr_reg;
        pend_data_next = pend_data_reg;
        if (wr_accept) begin
            pend_addr_next = wr_addr;
            pend_data_next = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            pend_v_reg    <= 1'b0;
            pend_addr_reg <= '0;
            pend_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            pend_v_reg    <= pend_v_next;
            pend_addr_reg <= pend_addr_next;
            pend_data_reg <= pend_data_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;

            assign word_en[gi] = pend_v_reg && (pend_addr_reg == AW'(gi));
            assign clr_en[gi]  = (state_reg == CLEAR) && (cnt_reg == AW'(gi));

            always_ff @(posedge clk) begin
                if (rst || clr_en[gi]) begin
                    entry_reg <= '0;
                end else if (word_en[gi]) begin
                    entry_reg <= pend_data_reg;
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    always_comb begin
        rd_data_a = entry_q[rd_addr_a];
        rd_data_b = entry_q[rd_addr_b];
`ifdef RF_BYPASS_EN
        if (pend_v_reg && (rd_addr_a == pend_addr_reg)) begin
            rd_data_a = pend_data_reg;
        end
        if (pend_v_reg && (rd_addr_b == pend_addr_reg)) begin
            rd_data_b = pend_data_reg;
        end
`endif
    end

endmodule
